// File: rtl/output_line_storer.sv
// output_line_storer: writes one channel-packed line-buffer line into the channel-planar OFM RAM.
// Latency: G*S*(OFM_DATA_NUM+1+R_BRAM_DATA_W) cycles after the start edge, then a one-cycle DONE.
// Backpressure: none; both RAMs are always ready, ap_start is honoured only in IDLE.
module output_line_storer #(
  parameter int OFM_DATA_NUM  = 4,
  parameter int R_BRAM_DATA_W = 16
) (
  input  logic                                                  clk,
  input  logic                                                  rstn,
  input  logic [8:0]                                            ofm_w,
  input  logic [8:0]                                            och,
  input  logic [7:0]                                            line_idx,
  input  logic                                                  ap_start,
  output logic                                                  r_en,
  output logic [$clog2(64*64/R_BRAM_DATA_W)-1:0]                r_addr,
  input  logic [8*R_BRAM_DATA_W-1:0]                            r_data,
  output logic                                                  w_en,
  output logic [$clog2(128*128*16/OFM_DATA_NUM)-1:0]            w_addr,
  output logic [8*OFM_DATA_NUM-1:0]                             w_data,
  output logic                                                  ap_done
);

  localparam int R_DATA_W  = 8 * R_BRAM_DATA_W;
  localparam int W_DATA_W  = 8 * OFM_DATA_NUM;
  localparam int LB_DEPTH  = $clog2(64 * 64 / R_BRAM_DATA_W);
  localparam int OFM_DEPTH = $clog2(128 * 128 * 16 / OFM_DATA_NUM);
  localparam int N_LOG     = $clog2(OFM_DATA_NUM);
  localparam int C_LOG     = $clog2(R_BRAM_DATA_W);
  localparam int P_W       = (N_LOG > 0) ? N_LOG : 1;
  localparam int C_W       = (C_LOG > 0) ? C_LOG : 1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [8:0]          r_g;
  logic [8:0]          r_s;
  logic [P_W-1:0]      r_p;
  logic [C_W-1:0]      r_c;
  logic                r_rd_vld;
  logic [P_W-1:0]      r_rd_idx;
  logic [R_DATA_W-1:0] r_pixbuf [OFM_DATA_NUM];

  logic [8:0]          w_grp_num;
  logic [8:0]          w_slc_num;
  logic                w_last_p;
  logic                w_last_c;
  logic                w_last_s;
  logic                w_last_gs;
  logic [31:0]         w_plane;
  logic [31:0]         w_raddr_full;
  logic [31:0]         w_waddr_full;
  logic [W_DATA_W-1:0] w_wdat;

  // Loop bounds: partial groups/slices are floored away.
  assign w_grp_num = ofm_w >> N_LOG;
  assign w_slc_num = och >> C_LOG;
  assign w_last_p  = (r_p == P_W'(OFM_DATA_NUM - 1));
  assign w_last_c  = (r_c == C_W'(R_BRAM_DATA_W - 1));
  assign w_last_s  = (r_s == w_slc_num - 9'd1);
  assign w_last_gs = w_last_s && (r_g == w_grp_num - 9'd1);

  // Words per channel plane of the OFM RAM; addresses are formed at 32b and truncated to port width.
  assign w_plane      = (32'(ofm_w) * 32'(ofm_w)) >> N_LOG;
  assign w_raddr_full = ((32'(r_g) << N_LOG) + 32'(r_p)) * 32'(w_slc_num) + 32'(r_s);
  assign w_waddr_full = 32'(line_idx) * 32'(w_grp_num) + 32'(r_g)
                      + ((32'(r_s) << C_LOG) + 32'(r_c)) * w_plane;

  // Transpose: byte i of the OFM word is channel c of the i-th buffered pixel.
  always_comb begin
    w_wdat = '0;
    for (int i = 0; i < OFM_DATA_NUM; i++) begin
      w_wdat[i*8 +: 8] = r_pixbuf[i][{r_c, 3'b000} +: 8];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and Moore outputs; everything is quiet outside READ/WRITE except ap_done.
  always_comb begin
    w_state_nxt = r_state;
    r_en        = 1'b0;
    r_addr      = '0;
    w_en        = 1'b0;
    w_addr      = '0;
    w_data      = '0;
    ap_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ap_start) begin
          w_state_nxt = (w_grp_num == 9'd0 || w_slc_num == 9'd0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        r_en   = 1'b1;
        r_addr = LB_DEPTH'(w_raddr_full);
        if (w_last_p) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        w_en   = 1'b1;
        w_addr = OFM_DEPTH'(w_waddr_full);
        w_data = w_wdat;
        if (w_last_c) w_state_nxt = w_last_gs ? S_DONE : S_READ;
      end
      S_DONE: begin
        ap_done     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Loop counters: p steps in READ, c in WRITE; s is the inner loop, g the outer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_g <= '0;
      r_s <= '0;
      r_p <= '0;
      r_c <= '0;
    end else begin
      case (r_state)
        S_READ: r_p <= w_last_p ? '0 : r_p + P_W'(1);
        S_WRITE: begin
          if (w_last_c) begin
            r_c <= '0;
            if (w_last_s) begin
              r_s <= '0;
              r_g <= r_g + 9'd1;
            end else begin
              r_s <= r_s + 9'd1;
            end
          end else begin
            r_c <= r_c + C_W'(1);
          end
        end
        S_WAIT: ;
        default: begin
          r_g <= '0;
          r_s <= '0;
          r_p <= '0;
          r_c <= '0;
        end
      endcase
    end
  end

  // Capture read data one cycle after its request (RAM latency of one).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_vld <= 1'b0;
      r_rd_idx <= '0;
      for (int i = 0; i < OFM_DATA_NUM; i++) r_pixbuf[i] <= '0;
    end else begin
      r_rd_vld <= (r_state == S_READ);
      r_rd_idx <= r_p;
      if (r_rd_vld) r_pixbuf[r_rd_idx] <= r_data;
    end
  end

endmodule

// File: tb/tb_output_line_storer.sv
// Directed bench for output_line_storer: LB/OFM RAM models plus per-scenario tasks with hand-derived expectations.
module tb_output_line_storer;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [8:0]   ofm_w = '0;
  logic [8:0]   och = '0;
  logic [7:0]   line_idx = '0;
  logic         ap_start = 1'b0;
  logic         r_en;
  logic [7:0]   r_addr;
  logic [127:0] r_data = '0;
  logic         w_en;
  logic [15:0]  w_addr;
  logic [31:0]  w_data;
  logic         ap_done;

  always #5 clk = ~clk;

  output_line_storer dut (
    .clk(clk), .rstn(rstn), .ofm_w(ofm_w), .och(och), .line_idx(line_idx),
    .ap_start(ap_start), .r_en(r_en), .r_addr(r_addr), .r_data(r_data),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .ap_done(ap_done)
  );

  logic [127:0] lb  [256];
  logic [31:0]  ofm [65536];

  // Line buffer with one-cycle read latency, OFM RAM with synchronous write.
  always @(posedge clk) begin
    if (r_en) r_data <= lb[r_addr];
    if (w_en) ofm[w_addr] <= w_data;
  end

  int n_vec = 0;
  int n_bad = 0;
  int done_cyc, both_hi, extra_act;
  logic [15:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [7:0]  ra_q[$];

  task automatic fill_pattern();
    for (int a = 0; a < 256; a++)
      for (int c = 0; c < 16; c++) lb[a][c*8 +: 8] = 8'(a * 16 + c);
  endtask

  // Runs one line and records everything seen on the RAM ports; cycle 1 is the first cycle after the start edge.
  task automatic run_line(input logic [8:0] w, input logic [8:0] ch, input logic [7:0] l, input bit hold);
    int cyc;
    wa_q.delete(); wd_q.delete(); ra_q.delete();
    done_cyc = -1; both_hi = 0; extra_act = 0;
    @(negedge clk);
    ofm_w = w; och = ch; line_idx = l; ap_start = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (done_cyc < 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (!hold) ap_start = 1'b0;
      if (r_en) ra_q.push_back(r_addr);
      if (w_en) begin wa_q.push_back(w_addr); wd_q.push_back(w_data); end
      if (r_en && w_en) both_hi++;
      if (ap_done) done_cyc = cyc;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (r_en || w_en || ap_done) extra_act++;
      ap_start = 1'b0;
    end
  endtask

  task automatic test_reset();
    #12;
    n_vec++; if ({r_en, w_en, ap_done} !== 3'b000) begin n_bad++; $display("FAIL reset_ctl: got %b expected 000", {r_en, w_en, ap_done}); end
    n_vec++; if (r_addr !== 8'h0) begin n_bad++; $display("FAIL reset_raddr: got %h expected 00", r_addr); end
    n_vec++; if (w_addr !== 16'h0 || w_data !== 32'h0) begin n_bad++; $display("FAIL reset_wport: got %h/%h expected 0/0", w_addr, w_data); end
    @(negedge clk); rstn = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if ({r_en, w_en, ap_done} !== 3'b000) begin n_bad++; $display("FAIL idle_ctl: got %b expected 000", {r_en, w_en, ap_done}); end
  endtask

  task automatic test_single_slice();
    logic [31:0] exp_d;
    int g, c;
    fill_pattern();
    run_line(9'd8, 9'd16, 8'd0, 1'b0);
    n_vec++; if (done_cyc !== 43) begin n_bad++; $display("FAIL t1_done: got %0d expected 43", done_cyc); end
    n_vec++; if (wa_q.size() !== 32) begin n_bad++; $display("FAIL t1_nwr: got %0d expected 32", wa_q.size()); end
    n_vec++; if (ra_q.size() !== 8) begin n_bad++; $display("FAIL t1_nrd: got %0d expected 8", ra_q.size()); end
    n_vec++; if (both_hi !== 0 || extra_act !== 0) begin n_bad++; $display("FAIL t1_excl: got %0d/%0d expected 0/0", both_hi, extra_act); end
    for (int k = 0; k < wa_q.size() && k < 32; k++) begin
      g = k / 16; c = k % 16;
      for (int i = 0; i < 4; i++) exp_d[i*8 +: 8] = 8'((4 * g + i) * 16 + c);
      n_vec++; if (wa_q[k] !== 16'(g + 16 * c)) begin n_bad++; $display("FAIL t1_waddr[%0d]: got %0d expected %0d", k, wa_q[k], g + 16 * c); end
      n_vec++; if (wd_q[k] !== exp_d) begin n_bad++; $display("FAIL t1_wdata[%0d]: got %h expected %h", k, wd_q[k], exp_d); end
    end
  endtask

  task automatic test_multi_slice();
    logic [7:0] exp_ra [16];
    logic [31:0] exp_d;
    int g, s, c;
    exp_ra = '{8'd0, 8'd2, 8'd4, 8'd6, 8'd1, 8'd3, 8'd5, 8'd7,
               8'd8, 8'd10, 8'd12, 8'd14, 8'd9, 8'd11, 8'd13, 8'd15};
    fill_pattern();
    run_line(9'd8, 9'd32, 8'd3, 1'b0);
    n_vec++; if (done_cyc !== 85) begin n_bad++; $display("FAIL t2_done: got %0d expected 85", done_cyc); end
    n_vec++; if (wa_q.size() !== 64) begin n_bad++; $display("FAIL t2_nwr: got %0d expected 64", wa_q.size()); end
    n_vec++; if (ra_q.size() !== 16) begin n_bad++; $display("FAIL t2_nrd: got %0d expected 16", ra_q.size()); end
    n_vec++; if (both_hi !== 0) begin n_bad++; $display("FAIL t2_excl: got %0d expected 0", both_hi); end
    for (int k = 0; k < ra_q.size() && k < 16; k++) begin
      n_vec++; if (ra_q[k] !== exp_ra[k]) begin n_bad++; $display("FAIL t2_raddr[%0d]: got %0d expected %0d", k, ra_q[k], exp_ra[k]); end
    end
    for (int k = 0; k < wa_q.size() && k < 64; k++) begin
      g = k / 32; s = (k / 16) % 2; c = k % 16;
      for (int i = 0; i < 4; i++) exp_d[i*8 +: 8] = 8'(((4 * g + i) * 2 + s) * 16 + c);
      n_vec++; if (wa_q[k] !== 16'(6 + g + 16 * (16 * s + c))) begin n_bad++; $display("FAIL t2_waddr[%0d]: got %0d expected %0d", k, wa_q[k], 6 + g + 16 * (16 * s + c)); end
      n_vec++; if (wd_q[k] !== exp_d) begin n_bad++; $display("FAIL t2_wdata[%0d]: got %h expected %h", k, wd_q[k], exp_d); end
    end
  endtask

  task automatic test_hold_start();
    logic [31:0] exp_d;
    int g, c;
    fill_pattern();
    for (int r = 0; r < 2; r++) begin
      run_line(9'd8, 9'd16, 8'd0, (r == 0));
      n_vec++; if (done_cyc !== 43) begin n_bad++; $display("FAIL t3_done run%0d: got %0d expected 43", r, done_cyc); end
      n_vec++; if (extra_act !== 0) begin n_bad++; $display("FAIL t3_rerun run%0d: got %0d active cycles expected 0", r, extra_act); end
      n_vec++; if (wa_q.size() !== 32) begin n_bad++; $display("FAIL t3_nwr run%0d: got %0d expected 32", r, wa_q.size()); end
      for (int k = 0; k < wa_q.size() && k < 32; k++) begin
        g = k / 16; c = k % 16;
        for (int i = 0; i < 4; i++) exp_d[i*8 +: 8] = 8'((4 * g + i) * 16 + c);
        n_vec++; if (wa_q[k] !== 16'(g + 16 * c) || wd_q[k] !== exp_d) begin n_bad++; $display("FAIL t3_wr run%0d[%0d]: got %0d/%h expected %0d/%h", r, k, wa_q[k], wd_q[k], g + 16 * c, exp_d); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int nwr, cyc, quiet;
    bit hit;
    logic [31:0] exp_d;
    fill_pattern();
    nwr = 0; cyc = 0; hit = 0; quiet = 0;
    @(negedge clk);
    ofm_w = 9'd8; och = 9'd16; line_idx = 8'd0; ap_start = 1'b1;
    while (!hit && cyc < 200) begin
      @(negedge clk);
      cyc++;
      ap_start = 1'b0;
      if (w_en) nwr++;
      if (nwr == 6) begin
        hit = 1;
        #1 rstn = 1'b0;
        #1;
        n_vec++; if ({r_en, w_en, ap_done} !== 3'b000) begin n_bad++; $display("FAIL t4_abort: got %b expected 000", {r_en, w_en, ap_done}); end
      end
    end
    n_vec++; if (hit !== 1'b1) begin n_bad++; $display("FAIL t4_reach_c5: got writes %0d expected 6", nwr); end
    @(negedge clk); rstn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (r_en || w_en || ap_done) quiet++;
    end
    n_vec++; if (quiet !== 0) begin n_bad++; $display("FAIL t4_quiet: got %0d active cycles expected 0", quiet); end
    for (int a = 0; a < 64; a++) ofm[a] = 32'hDEAD_BEEF;
    run_line(9'd8, 9'd16, 8'd0, 1'b0);
    n_vec++; if (done_cyc !== 43 || wa_q.size() !== 32) begin n_bad++; $display("FAIL t4_restart: got done %0d nwr %0d expected 43/32", done_cyc, wa_q.size()); end
    for (int g = 0; g < 2; g++)
      for (int c = 0; c < 16; c++) begin
        for (int i = 0; i < 4; i++) exp_d[i*8 +: 8] = 8'((4 * g + i) * 16 + c);
        n_vec++; if (ofm[g + 16 * c] !== exp_d) begin n_bad++; $display("FAIL t4_ofm[%0d]: got %h expected %h", g + 16 * c, ofm[g + 16 * c], exp_d); end
      end
  endtask

  task automatic test_empty();
    run_line(9'd8, 9'd8, 8'd0, 1'b0);
    n_vec++; if (done_cyc !== 1) begin n_bad++; $display("FAIL t5_s0_done: got %0d expected 1", done_cyc); end
    n_vec++; if (ra_q.size() !== 0 || wa_q.size() !== 0 || extra_act !== 0) begin n_bad++; $display("FAIL t5_s0_quiet: got rd %0d wr %0d extra %0d expected 0/0/0", ra_q.size(), wa_q.size(), extra_act); end
    run_line(9'd3, 9'd16, 8'd0, 1'b0);
    n_vec++; if (done_cyc !== 1) begin n_bad++; $display("FAIL t5_g0_done: got %0d expected 1", done_cyc); end
    n_vec++; if (ra_q.size() !== 0 || wa_q.size() !== 0) begin n_bad++; $display("FAIL t5_g0_quiet: got rd %0d wr %0d expected 0/0", ra_q.size(), wa_q.size()); end
  endtask

  // Reload through the line-loader mapping: LB word x*S+s byte c is pixel x of channel 16s+c.
  task automatic test_round_trip();
    logic [127:0] rebuilt;
    int x, s, chn, addr;
    for (int a = 0; a < 48; a++) lb[a] = {$urandom, $urandom, $urandom, $urandom};
    for (int a = 0; a < 4096; a++) ofm[a] = 32'hA5C3_5A3C;
    run_line(9'd16, 9'd48, 8'd7, 1'b0);
    n_vec++; if (done_cyc !== 253) begin n_bad++; $display("FAIL t6_done: got %0d expected 253", done_cyc); end
    n_vec++; if (wa_q.size() !== 192 || both_hi !== 0) begin n_bad++; $display("FAIL t6_nwr: got %0d overlap %0d expected 192/0", wa_q.size(), both_hi); end
    for (int a = 0; a < 48; a++) begin
      x = a / 3; s = a % 3;
      for (int c = 0; c < 16; c++) begin
        chn = s * 16 + c;
        addr = 7 * 4 + x / 4 + chn * 64;
        rebuilt[c*8 +: 8] = ofm[addr][(x % 4) * 8 +: 8];
      end
      n_vec++; if (rebuilt !== lb[a]) begin n_bad++; $display("FAIL t6_lb[%0d]: got %h expected %h", a, rebuilt, lb[a]); end
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) ofm[a] = '0;
    test_reset();
    test_single_slice();
    test_multi_slice();
    test_hold_start();
    test_reset_mid();
    test_empty();
    test_round_trip();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
